// File: rtl/if_id_fetch.sv
// rtl/if_id_fetch.sv - RV32I fetch stage and IF/ID register; FETCH_PERF_EN adds bubble/redirect counters
module if_id_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_bubble_o,
    output logic [31:0] perf_redirect_o,
`endif
    output logic        valid_o
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] skid_q;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        redirect;
    logic        unused_target_lsbs;

    assign target             = {branch_target_i[31:2], 2'b00};
    assign unused_target_lsbs = ^branch_target_i[1:0];
    assign pc_inc             = pc_q + 32'd4;
    assign redirect           = branch_taken_i & ~stall_i & (state != IDLE);

    // imem_addr_o only moves when a new request starts, so it stays put while a request is outstanding
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            pc_q        <= RESET_PC;
            skid_q      <= NOP_INSTR;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_PC;
            pc_o        <= 32'd0;
            instr_o     <= NOP_INSTR;
            valid_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= FETCH;
                    imem_req_o  <= 1'b1;
                    imem_addr_o <= pc_q;
                end
                FETCH: begin
                    if (stall_i) begin
                        if (imem_ack_i) begin
                            skid_q     <= imem_data_i;
                            state      <= HOLD;
                            imem_req_o <= 1'b0;
                        end
                    end else if (branch_taken_i) begin
                        pc_q    <= target;
                        instr_o <= NOP_INSTR;
                        valid_o <= 1'b0;
                        if (imem_ack_i) begin
                            imem_addr_o <= target;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (flush_i) begin
                        instr_o <= NOP_INSTR;
                        valid_o <= 1'b0;
                        // keep the returning instruction; it is the next one in program order
                        if (imem_ack_i) begin
                            skid_q     <= imem_data_i;
                            state      <= HOLD;
                            imem_req_o <= 1'b0;
                        end
                    end else if (imem_ack_i) begin
                        pc_o        <= pc_q;
                        instr_o     <= imem_data_i;
                        valid_o     <= 1'b1;
                        pc_q        <= pc_inc;
                        imem_addr_o <= pc_inc;
                    end else begin
                        instr_o <= NOP_INSTR;
                        valid_o <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        if (branch_taken_i) begin
                            pc_q        <= target;
                            imem_addr_o <= target;
                            instr_o     <= NOP_INSTR;
                            valid_o     <= 1'b0;
                            state       <= FETCH;
                            imem_req_o  <= 1'b1;
                        end else if (flush_i) begin
                            instr_o <= NOP_INSTR;
                            valid_o <= 1'b0;
                        end else begin
                            pc_o        <= pc_q;
                            instr_o     <= skid_q;
                            valid_o     <= 1'b1;
                            pc_q        <= pc_inc;
                            imem_addr_o <= pc_inc;
                            state       <= FETCH;
                            imem_req_o  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc_q <= target;
                    end
                    if (imem_ack_i) begin
                        state       <= FETCH;
                        imem_addr_o <= redirect ? target : pc_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_bubble_o   <= 32'd0;
            perf_redirect_o <= 32'd0;
        end else begin
            if (state != IDLE && !valid_o) begin
                perf_bubble_o <= perf_bubble_o + 32'd1;
            end
            if (redirect) begin
                perf_redirect_o <= perf_redirect_o + 32'd1;
            end
        end
    end
`endif

endmodule
